// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulation stage: default widths,
// derived chunk count, chunk-counter width and the FSM state encoding.
package mac_pkg;

    localparam int PROD_W_DEF  = 512;
    localparam int ACC_W_DEF   = 576;
    localparam int CHUNK_W_DEF = 64;
    localparam int NCHUNK_DEF  = ACC_W_DEF / CHUNK_W_DEF;

    // Counter width for n chunks; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_w(NCHUNK_DEF);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } mac_state_t;

endpackage

// File: rtl/mac_chunk_add.sv
// One CHUNK_W-bit slice adder with carry in/out. A single instance is
// time-shared across all accumulator slices by the top level.
module mac_chunk_add #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_full;

    // Widen to W+1 so the carry-out falls out of the same add.
    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    assign o_sum  = w_full[W-1:0];
    assign o_cout = w_full[W];

endmodule

// File: rtl/mac_accumulator.sv
// Serialised wide accumulator: each accepted product is added into the
// guard-bit accumulator one CHUNK_W slice per cycle, so no full-width
// carry chain exists. Optional build macro MAC_ACC_SAT_EN makes the sum
// saturate to all-ones on overflow instead of wrapping.
// ACC_W must be a multiple of CHUNK_W and at least PROD_W.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int CHUNK_W = CHUNK_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              acc_clr,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic              acc_ovf
);

    localparam int               NCHUNK = ACC_W / CHUNK_W;
    localparam int               CNT_W  = cnt_w(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NCHUNK - 1);

    mac_state_t         r_state;
    logic [CNT_W-1:0]   r_k;
    logic               r_carry;
    logic [ACC_W-1:0]   r_op;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic               r_valid;

    logic [CHUNK_W-1:0] w_acc_sl;
    logic [CHUNK_W-1:0] w_op_sl;
    logic [CHUNK_W-1:0] w_sum;
    logic               w_cout;

    // Slice mux: the shared adder always works on chunk r_k.
    assign w_acc_sl = r_acc[r_k*CHUNK_W +: CHUNK_W];
    assign w_op_sl  = r_op[r_k*CHUNK_W +: CHUNK_W];

    mac_chunk_add #(.W(CHUNK_W)) u_add (
        .i_a    (w_acc_sl),
        .i_b    (w_op_sl),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign prod_ready = (r_state == IDLE);
    assign acc_out    = r_acc;
    assign acc_valid  = r_valid;
    assign acc_ovf    = r_ovf;

    // FSM plus all datapath registers. The final carry is folded into the
    // overflow flag on the edge entering DONE so acc_ovf and acc_valid
    // change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_op    <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A clear with a handshake makes zero the base of the add.
                    if (acc_clr) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                    if (prod_valid) begin
                        r_op    <= ACC_W'(prod_data);
                        r_k     <= '0;
                        r_carry <= 1'b0;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (r_k == CNT_W'(i)) r_acc[i*CHUNK_W +: CHUNK_W] <= w_sum;
                    end
                    r_carry <= w_cout;
                    r_k     <= r_k + CNT_W'(1);
                    if (r_k == LAST_K) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_ovf   <= r_ovf | w_cout;
`ifdef MAC_ACC_SAT_EN
                        // Overrides the top-slice write above.
                        if (w_cout) r_acc <= '1;
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a default-width instance and a small
// 64/64/32 instance (for overflow), both checked against arithmetic models.
module tb_mac_accumulator;

    localparam int PW  = 512;
    localparam int AW  = 576;
    localparam int CW  = 64;
    localparam int NCH = AW / CW;
    localparam int AW1 = AW + 1;
    localparam int SPW = 64;
    localparam int SAW = 64;
    localparam int SCW = 32;
    localparam int SNCH = SAW / SCW;
    localparam int SAW1 = SAW + 1;
`ifdef MAC_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          prod_valid = 1'b0;
    logic          acc_clr = 1'b0;
    logic [PW-1:0] prod_data = '0;
    logic          prod_ready;
    logic [AW-1:0] acc_out;
    logic          acc_valid;
    logic          acc_ovf;

    logic           s_prod_valid = 1'b0;
    logic           s_acc_clr = 1'b0;
    logic [SPW-1:0] s_prod_data = '0;
    logic           s_prod_ready;
    logic [SAW-1:0] s_acc_out;
    logic           s_acc_valid;
    logic           s_acc_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    logic [AW-1:0]  m_acc = '0;
    logic           m_ovf = 1'b0;
    logic [SAW-1:0] ms_acc = '0;
    logic           ms_ovf = 1'b0;

    mac_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .acc_clr    (acc_clr),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ovf    (acc_ovf)
    );

    mac_accumulator #(.PROD_W(SPW), .ACC_W(SAW), .CHUNK_W(SCW)) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_valid (s_prod_valid),
        .prod_ready (s_prod_ready),
        .prod_data  (s_prod_data),
        .acc_clr    (s_acc_clr),
        .acc_out    (s_acc_out),
        .acc_valid  (s_acc_valid),
        .acc_ovf    (s_acc_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [PW-1:0] rand_prod();
        logic [PW-1:0] v;
        for (int j = 0; j < PW/32; j++) v[j*32 +: 32] = $urandom;
        case ($urandom_range(0, 3))
            0: v = PW'(v[15:0]);
            1: v = '1;
            2: v = PW'(v[63:0]) << (64 * $urandom_range(0, 7));
            default: ;
        endcase
        return v;
    endfunction

    // Reference: unsigned add with carry-out, wrap or saturate.
    task automatic m_add(input logic [PW-1:0] p, input bit clr);
        logic [AW:0] t;
        if (clr) begin m_acc = '0; m_ovf = 1'b0; end
        t = {1'b0, m_acc} + AW1'(p);
        m_acc = t[AW-1:0];
        if (t[AW]) begin
            m_ovf = 1'b1;
            if (SAT) m_acc = '1;
        end
    endtask

    task automatic ms_add(input logic [SPW-1:0] p, input bit clr);
        logic [SAW:0] t;
        if (clr) begin ms_acc = '0; ms_ovf = 1'b0; end
        t = {1'b0, ms_acc} + SAW1'(p);
        ms_acc = t[SAW-1:0];
        if (t[SAW]) begin
            ms_ovf = 1'b1;
            if (SAT) ms_acc = '1;
        end
    endtask

    task automatic add_big(input logic [PW-1:0] p, input bit clr);
        int lat;
        bit seen;
        @(negedge clk);
        chk("ready_idle", AW'(prod_ready), AW'(1));
        prod_valid = 1'b1; prod_data = p; acc_clr = clr;
        @(posedge clk); #1;
        prod_valid = 1'b0; acc_clr = 1'b0; prod_data = rand_prod();
        m_add(p, clr);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk); lat++;
            if (acc_valid) seen = 1'b1;
        end
        chk("valid_seen", AW'(seen), AW'(1));
        chk("latency", AW'(lat), AW'(NCH + 1));
        chk("acc_out", acc_out, m_acc);
        chk("acc_ovf", AW'(acc_ovf), AW'(m_ovf));
        chk("ready_in_done", AW'(prod_ready), AW'(0));
        @(negedge clk);
        chk("valid_one_cycle", AW'(acc_valid), AW'(0));
        chk("ready_back", AW'(prod_ready), AW'(1));
    endtask

    task automatic add_small(input logic [SPW-1:0] p, input bit clr);
        int lat;
        bit seen;
        @(negedge clk);
        chk("s_ready_idle", AW'(s_prod_ready), AW'(1));
        s_prod_valid = 1'b1; s_prod_data = p; s_acc_clr = clr;
        @(posedge clk); #1;
        s_prod_valid = 1'b0; s_acc_clr = 1'b0; s_prod_data = {$urandom, $urandom};
        ms_add(p, clr);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk); lat++;
            if (s_acc_valid) seen = 1'b1;
        end
        chk("s_valid_seen", AW'(seen), AW'(1));
        chk("s_latency", AW'(lat), AW'(SNCH + 1));
        chk("s_acc_out", AW'(s_acc_out), AW'(ms_acc));
        chk("s_acc_ovf", AW'(s_acc_ovf), AW'(ms_ovf));
        @(negedge clk);
        chk("s_ready_back", AW'(s_prod_ready), AW'(1));
    endtask

    task automatic clear_big();
        @(negedge clk); acc_clr = 1'b1;
        @(negedge clk); acc_clr = 1'b0;
        m_acc = '0; m_ovf = 1'b0;
        chk("clr_out", acc_out, m_acc);
        chk("clr_ovf", AW'(acc_ovf), AW'(0));
        chk("clr_no_valid", AW'(acc_valid), AW'(0));
    endtask

    task automatic stall_test();
        int idx;
        int t[$];
        idx = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (acc_valid) t.push_back(cyc);
            if (idx < 3) begin
                prod_valid = 1'b1;
                acc_clr = (idx == 0);
                if (prod_ready) begin
                    prod_data = PW'(5 + 2 * idx);
                    m_add(prod_data, idx == 0);
                    idx++;
                end else begin
                    prod_data = rand_prod();
                end
            end else begin
                prod_valid = 1'b0;
                acc_clr = 1'b0;
            end
        end
        chk("stall_strobes", AW'(t.size()), AW'(3));
        if (t.size() >= 3) begin
            chk("stall_gap1", AW'(t[1] - t[0]), AW'(NCH + 2));
            chk("stall_gap2", AW'(t[2] - t[1]), AW'(NCH + 2));
        end
        chk("stall_sum", acc_out, AW'(21));
        chk("stall_model", acc_out, m_acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit seen;
        logic [AW-1:0] e;

        // Reset / idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", AW'(prod_ready), AW'(1));
        chk("rst_out", acc_out, AW'(0));
        chk("rst_valid", AW'(acc_valid), AW'(0));
        chk("rst_ovf", AW'(acc_ovf), AW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", AW'(prod_ready), AW'(1));
        chk("idle_out", acc_out, AW'(0));
        chk("s_idle_out", AW'(s_acc_out), AW'(0));

        // Single add with clear
        add_big(PW'(16'h1234), 1'b1);
        chk("single_1234", acc_out, AW'(16'h1234));

        // Cross-chunk carry
        add_big(PW'(1), 1'b1);
        add_big(PW'({64{1'b1}}), 1'b0);
        e = AW'(1) << 64;
        chk("carry_2p64", acc_out, e);
        chk("carry_no_ovf", AW'(acc_ovf), AW'(0));
        add_big('1, 1'b0);
        e = (AW'(1) << 512) + (AW'(1) << 64) - AW'(1);
        chk("carry_2p512", acc_out, e);

        // Back-to-back with stall
        stall_test();

        // Reset mid-ADD
        @(negedge clk);
        prod_valid = 1'b1; prod_data = PW'(77); acc_clr = 1'b0;
        @(posedge clk); #1;
        prod_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", acc_out, AW'(0));
        chk("midrst_valid", AW'(acc_valid), AW'(0));
        chk("midrst_ready", AW'(prod_ready), AW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = '0; m_ovf = 1'b0; ms_acc = '0; ms_ovf = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (acc_valid) seen = 1'b1;
        end
        chk("midrst_no_strobe", AW'(seen), AW'(0));
        add_big(PW'(3), 1'b0);
        chk("midrst_then_3", acc_out, AW'(3));

        // Randomized accumulation with occasional clears
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 5) == 0) clear_big();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            add_big(rand_prod(), $urandom_range(0, 7) == 0);
        end

        // Overflow on the small build
        add_small('1, 1'b1);
        chk("s_allones", AW'(s_acc_out), AW'({64{1'b1}}));
        chk("s_no_ovf", AW'(s_acc_ovf), AW'(0));
        add_small(SPW'(2), 1'b0);
        chk("s_ovf_out", AW'(s_acc_out), SAT ? AW'({64{1'b1}}) : AW'(1));
        chk("s_ovf_flag", AW'(s_acc_ovf), AW'(1));
        add_small(SPW'(5), 1'b0);
        chk("s_ovf_sticky", AW'(s_acc_ovf), AW'(1));
        @(negedge clk); s_acc_clr = 1'b1;
        @(negedge clk); s_acc_clr = 1'b0;
        ms_acc = '0; ms_ovf = 1'b0;
        chk("s_clr_out", AW'(s_acc_out), AW'(0));
        chk("s_clr_ovf", AW'(s_acc_ovf), AW'(0));
        chk("s_clr_no_valid", AW'(s_acc_valid), AW'(0));

        for (int i = 0; i < 20; i++) begin
            logic [SPW-1:0] p;
            p = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) p = p >> $urandom_range(0, 63);
            add_small(p, $urandom_range(0, 5) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
